// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit resolving branch flushes, multi-cycle EX stalls and load-use stalls.
// Hazard detection is same-cycle combinational; only the FSM state, stall counter and perf counters are registered.
module hazard_ctrl #(
    parameter logic [4:0] LOAD_OP   = 5'd3,
    parameter logic [4:0] BRANCH_OP = 5'd11,
    parameter logic [4:0] MULTI_OP  = 5'd7,
    parameter int         MULTI_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_opcode,
    input  logic [8:0]  id_rs,
    input  logic [8:0]  id_rt,
    input  logic [4:0]  ex_opcode,
    input  logic [8:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        clr_cnt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'd0, MC_STALL = 2'd1, FLUSH = 2'd2} state_t;
    state_t     st;
    logic [3:0] cnt;
    logic       br, mc, lu, hold, stall, unused_id;
    assign unused_id = ^id_opcode;
    always_comb begin
        br    = st == RUN && ex_opcode == BRANCH_OP && branch_taken;
        mc    = st == RUN && !br && ex_opcode == MULTI_OP && MULTI_LAT > 1;
        lu    = st == RUN && !br && !mc && ex_opcode == LOAD_OP && ex_rd != '0 &&
                (ex_rd == id_rs || ex_rd == id_rt);
        hold  = st == MC_STALL && cnt != '0;
        stall = mc || hold;
        pc_en        = rst && !stall && !lu;
        ifid_en      = rst && !stall && !lu;
        idex_en      = rst && !stall;
        ifid_flush   = !rst || br || st == FLUSH;
        idex_bubble  = !rst || br || lu;
        exmem_bubble = !rst || stall;
    end
    // Reset wins over everything, including a stall or flush in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st        <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            st        <= br ? FLUSH : (mc || hold) ? MC_STALL : RUN;
            cnt       <= mc ? 4'(MULTI_LAT - 2) : hold ? cnt - 4'd1 : cnt;
            stall_cnt <= clr_cnt ? '0 : (!pc_en && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
            flush_cnt <= clr_cnt ? '0 : (br && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
        end
    end
    assign state = st;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
    logic        clk = 0, rst = 0, branch_taken = 0, clr_cnt = 0;
    logic [4:0]  id_opcode = 0, ex_opcode = 0;
    logic [8:0]  id_rs = 0, id_rt = 0, ex_rd = 0;
    logic        pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic [5:0]  outs;
    int          errors = 0, checks = 0;

    localparam logic [5:0] DEF = 6'b111000, LU = 6'b001010, STALL = 6'b000001;
    localparam logic [5:0] BR = 6'b111110, FL = 6'b111100, RST = 6'b000111;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .branch_taken(branch_taken), .clr_cnt(clr_cnt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign outs = {pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exmem_bubble};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_opcode = 0; id_rs = 0; id_rt = 0; ex_opcode = 0; ex_rd = 0;
        branch_taken = 0; clr_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 0; idle();
        #2;
        checks++; if (outs !== RST) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, RST); end
        tick(); tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        rst = 1;
        #2;
        checks++; if (outs !== DEF) begin errors++; $display("FAIL reset_release: got %b expected %b", outs, DEF); end
        tick();
    endtask

    task automatic test_load_use();
        ex_opcode = 3; ex_rd = 9'd6; id_rs = 9'd6;
        #2;
        checks++; if (outs !== LU || state !== 2'd0) begin errors++; $display("FAIL lu_rs: got %b st %0d expected %b st 0", outs, state, LU); end
        tick(); idle();
        #2;
        checks++; if (outs !== DEF || state !== 2'd0 || stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_after: got %b st %0d sc %0d expected %b st 0 sc 1", outs, state, stall_cnt, DEF); end
        ex_opcode = 3; ex_rd = 9'h1FF; id_rt = 9'h1FF; id_opcode = 5'd31;
        #2;
        checks++; if (outs !== LU) begin errors++; $display("FAIL lu_rt: got %b expected %b", outs, LU); end
        tick(); idle();
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_rt_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_r0();
        ex_opcode = 3; ex_rd = 0; id_rs = 0; id_rt = 0;
        #2;
        checks++; if (outs !== DEF) begin errors++; $display("FAIL r0: got %b expected %b", outs, DEF); end
        ex_rd = 9'd5; id_rs = 9'd4; id_rt = 9'd3;
        #1;
        checks++; if (outs !== DEF) begin errors++; $display("FAIL lu_nomatch: got %b expected %b", outs, DEF); end
        tick(); idle();
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL r0_cnt: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_multi();
        logic [1:0] es [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
        logic [5:0] eo [4] = '{STALL, STALL, STALL, DEF};
        ex_opcode = 7;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++; if (outs !== eo[i] || state !== es[i]) begin errors++; $display("FAIL multi_c%0d: got %b st %0d expected %b st %0d", i, outs, state, eo[i], es[i]); end
            if (i == 3) idle();
            tick();
        end
        checks++; if (state !== 2'd0 || stall_cnt !== 16'd5) begin errors++; $display("FAIL multi_end: got st %0d sc %0d expected st 0 sc 5", state, stall_cnt); end
    endtask

    task automatic test_branch();
        ex_opcode = 11; branch_taken = 1;
        #2;
        checks++; if (outs !== BR || state !== 2'd0) begin errors++; $display("FAIL br_n: got %b st %0d expected %b st 0", outs, state, BR); end
        tick();
        #2;
        checks++; if (outs !== FL || state !== 2'd2 || flush_cnt !== 16'd1) begin errors++; $display("FAIL br_n1: got %b st %0d fc %0d expected %b st 2 fc 1", outs, state, flush_cnt, FL); end
        idle();
        tick();
        checks++; if (outs !== DEF || state !== 2'd0 || flush_cnt !== 16'd1) begin errors++; $display("FAIL br_n2: got %b st %0d fc %0d expected %b st 0 fc 1", outs, state, flush_cnt, DEF); end
    endtask

    task automatic test_not_taken();
        ex_opcode = 11; branch_taken = 0;
        #2;
        checks++; if (outs !== DEF) begin errors++; $display("FAIL nt_outs: got %b expected %b", outs, DEF); end
        tick(); idle();
        checks++; if (flush_cnt !== 16'd1 || state !== 2'd0) begin errors++; $display("FAIL nt_cnt: got fc %0d st %0d expected fc 1 st 0", flush_cnt, state); end
    endtask

    task automatic test_priority();
        ex_opcode = 7; ex_rd = 9'd2; id_rs = 9'd2;
        #2;
        checks++; if (outs !== STALL) begin errors++; $display("FAIL prio_multi: got %b expected %b", outs, STALL); end
        idle();
        #1;
    endtask

    task automatic test_clr();
        ex_opcode = 3; ex_rd = 9'd6; id_rs = 9'd6; clr_cnt = 1;
        #2;
        checks++; if (outs !== LU) begin errors++; $display("FAIL clr_outs: got %b expected %b", outs, LU); end
        tick(); idle();
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_reset_mid();
        ex_opcode = 3; ex_rd = 9'd1; id_rt = 9'd1;
        tick(); idle();
        ex_opcode = 7;
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rm_state: got %0d expected 1", state); end
        rst = 0;
        #2;
        checks++; if (outs !== RST) begin errors++; $display("FAIL rm_outs: got %b expected %b", outs, RST); end
        tick();
        checks++; if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rm_clear: got st %0d sc %0d fc %0d expected 0 0 0", state, stall_cnt, flush_cnt); end
        rst = 1; idle();
        #2;
        checks++; if (outs !== DEF || state !== 2'd0) begin errors++; $display("FAIL rm_release: got %b st %0d expected %b st 0", outs, state, DEF); end
        tick();
    endtask

    task automatic test_saturate();
        ex_opcode = 3; ex_rd = 9'd6; id_rs = 9'd6;
        for (int i = 0; i < 65537; i++) tick();
        idle();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat: got %h expected ffff", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_multi();
        test_branch();
        test_not_taken();
        test_priority();
        test_clr();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_OP, 5'd3, EX opcode that is a memory load.
REQ-002 Parameter BRANCH_OP, 5'd11, EX opcode that is a conditional branch.
REQ-003 Parameter MULTI_OP, 5'd7, EX opcode that is a multi-cycle operation.
REQ-004 Parameter MULTI_LAT, 4, total EX cycles of MULTI_OP; legal range 1..15.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 id_opcode  input  5  opcode of the instruction in ID (IF/ID output).
REQ-008 id_rs, id_rt  input  9 each  source register indices of the ID instruction.
REQ-009 ex_opcode  input  5  OpCodeOut of the ID/EX register.
REQ-010 ex_rd  input  9  RdOut of the ID/EX register.
REQ-011 branch_taken  input  1  EX branch outcome; meaningful only when ex_opcode==BRANCH_OP.
REQ-012 clr_cnt  input  1  synchronous clear of the performance counters.
REQ-013 pc_en, ifid_en, idex_en  output  1 each  load enables for the PC, IF/ID and ID/EX registers.
REQ-014 ifid_flush  output  1  IF/ID loads a NOP.
REQ-015 idex_bubble  output  1  ID/EX loads a NOP.
REQ-016 exmem_bubble  output  1  EX/MEM loads a NOP.
REQ-017 state  output  2  FSM state: RUN=0, MC_STALL=1, FLUSH=2.
REQ-018 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-019 The FSM SHALL have states RUN, MC_STALL and FLUSH; encoding 3 is unused and SHALL return to RUN on the next edge.
REQ-020 Default outputs (no condition active) SHALL be all enables 1 and all bubble/flush signals 0.
REQ-021 In RUN, hazard detection SHALL be combinational and same-cycle, with priority branch > multi-cycle > load-use.
REQ-022 Branch: in RUN, ex_opcode==BRANCH_OP with branch_taken=1 SHALL assert ifid_flush=1 and idex_bubble=1 in that cycle, with enables 1, and SHALL move the FSM to FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle with ifid_flush=1, idex_bubble=0 and enables 1, to squash the delayed fetch; no hazard evaluation; next state RUN.
REQ-024 Multi-cycle: in RUN, ex_opcode==MULTI_OP with MULTI_LAT>1 SHALL assert pc_en=ifid_en=idex_en=0 and exmem_bubble=1, load cnt<=MULTI_LAT-2 and enter MC_STALL.
REQ-025 With MULTI_LAT==1, MULTI_OP SHALL cause no stall and no state change.
REQ-026 In MC_STALL with cnt!=0, the block SHALL hold the same stall outputs and decrement cnt.
REQ-027 In MC_STALL with cnt==0, the block SHALL drive default outputs (release) and return to RUN.
REQ-028 Total stall cycles per MULTI_OP SHALL be exactly MULTI_LAT-1.
REQ-029 Load-use: in RUN, ex_opcode==LOAD_OP with ex_rd!=0 and (ex_rd==id_rs or ex_rd==id_rt) SHALL assert pc_en=ifid_en=0 and idex_bubble=1 for that cycle only, with idex_en=1 and no state change.
REQ-030 Register index 0 SHALL never create a hazard.
REQ-031 id_opcode SHALL NOT gate load-use detection; every ID instruction is treated as reading Rs and Rt.
REQ-032 stall_cnt SHALL increment on every cycle with rst=1 and pc_en=0.
REQ-033 flush_cnt SHALL increment on every cycle in which REQ-022 fires.
REQ-034 Both counters SHALL saturate at 16'hFFFF.
REQ-035 clr_cnt=1 SHALL zero both counters on the next edge, overriding any increment in the same cycle.

Reset
REQ-036 While rst=0, outputs SHALL be combinationally forced to pc_en=ifid_en=idex_en=0 and ifid_flush=idex_bubble=exmem_bubble=1.
REQ-037 On an edge with rst=0, the block SHALL set state=RUN, cnt=0 and stall_cnt=flush_cnt=0, including mid-MC_STALL and mid-FLUSH.
REQ-038 In the first cycle after rst returns to 1, outputs SHALL follow RUN rules.

Verification
REQ-039 Load-use: ex_opcode=3, ex_rd=9'd6, id_rs=9'd6 -> pc_en=0, ifid_en=0, idex_bubble=1 for 1 cycle, state stays 0, stall_cnt=1.
REQ-040 No hazard on r0: ex_opcode=3, ex_rd=0, id_rt=0 -> default outputs.
REQ-041 Multi-cycle, MULTI_LAT=4: ex_opcode=7 held -> stall in cycles N, N+1, N+2 and release in N+3; state 0,1,1,1 then 0; stall_cnt=3.
REQ-042 Taken branch: ex_opcode=11, branch_taken=1 -> cycle N: ifid_flush=1, idex_bubble=1; N+1: state=2, ifid_flush=1, idex_bubble=0; N+2: RUN; flush_cnt=1.
REQ-043 Not-taken branch: ex_opcode=11, branch_taken=0 -> default outputs, flush_cnt unchanged.
REQ-044 Reset mid-MC_STALL: rst=0 during cycle N+1 of REQ-041 -> reset outputs per REQ-036; after release, state=0 and counters=0.
